// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master sharing logic.
// Status word bit positions, command-word field offsets, arbiter FSM
// state encoding and small helpers for building and decoding words.
package i2c_pkg;

  // Status word returned by I2C_master and forwarded to requesters
  localparam int unsigned STAT_BUSY    = 31;
  localparam int unsigned STAT_NACK    = 30;
  localparam int unsigned STAT_TIMEOUT = 29;

  // Command word: {8'h00, slave_addr[7:0], reg_addr[7:0], data[7:0]}
  localparam int unsigned CMD_DATA_LSB  = 0;
  localparam int unsigned CMD_REG_LSB   = 8;
  localparam int unsigned CMD_SLAVE_LSB = 16;

  // Completion status reported when the bus never finishes
  localparam logic [31:0] TIMEOUT_STATUS = 32'h1 << STAT_TIMEOUT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESPOND
  } arb_state_t;

  function automatic logic [31:0] cmd_word(input logic [7:0] slave_addr,
                                           input logic [7:0] reg_addr,
                                           input logic [7:0] data);
    logic [31:0] w;
    w = '0;
    w[CMD_SLAVE_LSB +: 8] = slave_addr;
    w[CMD_REG_LSB   +: 8] = reg_addr;
    w[CMD_DATA_LSB  +: 8] = data;
    return w;
  endfunction

  function automatic logic is_error(input logic [31:0] status);
    return status[STAT_NACK] | status[STAT_TIMEOUT];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Selects the first asserted request at or after ptr, wrapping modulo N.
//   req   : request vector
//   ptr   : highest-priority index this round
//   gnt   : one-hot grant (all zero when nothing requested)
//   idx   : binary index of the granted request
//   valid : at least one request present
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr + k folded back into 0..N-1 without a modulo operator
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one I2C_master between
// N_REQ requesters. Issues the winner's command word, follows the master
// busy flag to completion (bounded by a timeout) and returns the captured
// status to the winner with a one-cycle done pulse.
//   sys_clock, reset : clock, synchronous active-high reset
//   req, req_data    : per-requester request level and 32-bit command word
//   gnt, done        : one-hot ownership, one-cycle completion pulse
//   rsp_status       : completion status, valid from the done cycle on
//   m_ctrl_data      : command word to the master
//   m_wr_ctrl        : one-cycle start pulse to the master
//   m_status         : master status (31 busy, 30 NACK, 7:0 read data)
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [31:0]          rsp_status,
  output logic [31:0]          m_ctrl_data,
  output logic                 m_wr_ctrl,
  input  logic [31:0]          m_status
);

  localparam int unsigned IW      = $clog2(N_REQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t    state, state_nx;
  logic [IW-1:0] rr_ptr, rr_ptr_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [15:0]   cnt, cnt_nx;
  logic [N_REQ-1:0] gnt_nx, done_nx;
  logic          wr_nx;
  logic [31:0]   ctrl_nx, rsp_nx;

  logic [N_REQ-1:0] req_eligible;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  // The owner's req is typically still high during its done cycle; masking
  // it here keeps that stale level from being granted a second time.
  assign req_eligible = req & ~done;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req   (req_eligible),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    owner_nx  = owner;
    cnt_nx    = cnt;
    gnt_nx    = gnt;
    done_nx   = '0;
    wr_nx     = 1'b0;
    ctrl_nx   = m_ctrl_data;
    rsp_nx    = rsp_status;

    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_nx = pick_idx;
          gnt_nx   = pick_gnt;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) ctrl_nx = req_data[32*i +: 32];
          end
          state_nx = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wr_nx    = 1'b1;
        cnt_nx   = '0;
        state_nx = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        cnt_nx = cnt + 16'd1;
        if (cnt >= TO_LAST) begin
          rsp_nx   = TIMEOUT_STATUS;
          state_nx = ST_RESPOND;
        end else if (m_status[STAT_BUSY]) begin
          state_nx = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        cnt_nx = cnt + 16'd1;
        if (!m_status[STAT_BUSY]) begin
          rsp_nx               = m_status;
          rsp_nx[STAT_TIMEOUT] = 1'b0;
          state_nx             = ST_RESPOND;
        end else if (cnt >= TO_LAST) begin
          rsp_nx   = TIMEOUT_STATUS;
          state_nx = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        done_nx   = gnt;
        gnt_nx    = '0;
        rr_ptr_nx = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
        state_nx  = ST_IDLE;
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      m_wr_ctrl   <= 1'b0;
      m_ctrl_data <= '0;
      rsp_status  <= '0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_ptr_nx;
      owner       <= owner_nx;
      cnt         <= cnt_nx;
      gnt         <= gnt_nx;
      done        <= done_nx;
      m_wr_ctrl   <= wr_nx;
      m_ctrl_data <= ctrl_nx;
      rsp_status  <= rsp_nx;
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter with a behavioural I2C master.
module tb_i2c_master_arbiter;
  import i2c_pkg::*;

  localparam int unsigned N = 4;

  logic              sys_clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [32*N-1:0]   req_data;
  logic [N-1:0]      gnt;
  logic [N-1:0]      done;
  logic [31:0]       rsp_status;
  logic [31:0]       m_ctrl_data;
  logic              m_wr_ctrl;
  logic [31:0]       m_status;

  i2c_master_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .rsp_status  (rsp_status),
    .m_ctrl_data (m_ctrl_data),
    .m_wr_ctrl   (m_wr_ctrl),
    .m_status    (m_status)
  );

  always #5 sys_clock = ~sys_clock;

  int cyc = 0;
  always @(posedge sys_clock) cyc <= cyc + 1;

  // ---------------- master model ----------------
  logic [31:0] model_result = 32'h0;
  int          model_busy_len = 50;
  bit          model_hang = 1'b0;
  int          dly = 0;
  int          busy_left = 0;

  always @(posedge sys_clock) begin
    if (m_wr_ctrl && !model_hang) dly <= 2;
    else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) busy_left <= model_busy_len;
    end else if (busy_left > 0) busy_left <= busy_left - 1;
  end

  assign m_status = (busy_left > 0) ? 32'h8000_0000 : model_result;

  // ---------------- scoreboard ----------------
  typedef struct { int idx; logic [31:0] data; } exp_ctrl_t;
  typedef struct { int idx; logic [31:0] status; bit chk_lat; } exp_rsp_t;
  exp_ctrl_t ctrl_q[$];
  exp_rsp_t  rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cyc   = 0;

  logic [31:0] dw [N];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [31:0] status, input bit lat);
    exp_ctrl_t c;
    exp_rsp_t  r;
    c.idx = i; c.data = dw[i];
    r.idx = i; r.status = status; r.chk_lat = lat;
    ctrl_q.push_back(c);
    rsp_q.push_back(r);
  endtask

  // Monitor: compares every start pulse and every completion against queues
  always @(negedge sys_clock) begin
    exp_ctrl_t c;
    exp_rsp_t  r;
    if (m_wr_ctrl) begin
      if (ctrl_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_wr: got m_wr_ctrl=1 data %h, required no pulse", m_ctrl_data);
      end else begin
        c = ctrl_q.pop_front();
        check32("wr_ctrl_data", m_ctrl_data, c.data);
        check32("wr_gnt", 32'(gnt), 32'h1 << c.idx);
      end
      wr_cyc = cyc;
    end
    if (done != '0) begin
      if (rsp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=%b, required none", done);
      end else begin
        r = rsp_q.pop_front();
        check32("done_onehot", 32'(done), 32'h1 << r.idx);
        check32("rsp_status", rsp_status, r.status);
        check32("gnt_cleared", 32'(gnt), 32'h0);
        if (r.chk_lat) begin
          n_checks++;
          if ((cyc - wr_cyc) < 99 || (cyc - wr_cyc) > 101) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles, required 100 +/- 1", cyc - wr_cyc);
          end
        end
      end
    end
  end

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    do begin @(negedge sys_clock); n++; end while (!done[i] && n < budget);
    n_checks++;
    if (!done[i]) begin
      n_fail++;
      $display("FAIL wait_done_%0d: got no done within %0d cycles, required a pulse", i, budget);
    end
  endtask

  task automatic wait_status(input logic busy_val, input int budget);
    int n;
    n = 0;
    while (m_status[31] !== busy_val && n < budget) begin @(negedge sys_clock); n++; end
    n_checks++;
    if (m_status[31] !== busy_val) begin
      n_fail++;
      $display("FAIL wait_busy: got busy=%b, required %b within %0d cycles", m_status[31], busy_val, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dw[0] = cmd_word(8'h66, 8'h55, 8'h44);
    dw[1] = cmd_word(8'hA0, 8'h12, 8'h34);
    dw[2] = cmd_word(8'h50, 8'h01, 8'h02);
    dw[3] = cmd_word(8'h7C, 8'h0F, 8'h0E);
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = dw[i];

    // Reset state
    repeat (3) @(negedge sys_clock);
    check32("rst_gnt", 32'(gnt), 32'h0);
    check32("rst_done", 32'(done), 32'h0);
    check32("rst_wr", 32'(m_wr_ctrl), 32'h0);
    check32("rst_ctrl", m_ctrl_data, 32'h0);
    check32("rst_rsp", rsp_status, 32'h0);
    reset = 1'b0;
    @(negedge sys_clock);

    // Round robin: ptr 0 -> 0 then 2; ptr 3 wraps -> 0 then 2 again
    model_result = 32'h0000_0011;
    model_busy_len = 20;
    for (int round = 0; round < 2; round++) begin
      push_exp(0, 32'h0000_0011, 1'b0);
      push_exp(2, 32'h0000_0011, 1'b0);
      req[0] = 1'b1; req[2] = 1'b1;
      wait_done(0, 200); req[0] = 1'b0;
      wait_done(2, 200); req[2] = 1'b0;
      repeat (3) @(negedge sys_clock);
    end

    // Single request, busy 50 cycles; status bit 29 from master is dropped
    model_result = 32'h2000_0044;
    model_busy_len = 50;
    push_exp(0, 32'h0000_0044, 1'b0);
    req[0] = 1'b1;
    wait_done(0, 200); req[0] = 1'b0;
    repeat (3) @(negedge sys_clock);

    // NACK passthrough
    model_result = 32'h4000_00A5;
    model_busy_len = 5;
    push_exp(1, 32'h4000_00A5, 1'b0);
    req[1] = 1'b1;
    wait_done(1, 100); req[1] = 1'b0;
    repeat (3) @(negedge sys_clock);

    // Timeout: master never goes busy
    model_hang = 1'b1;
    push_exp(2, 32'h2000_0000, 1'b1);
    req[2] = 1'b1;
    wait_done(2, 300); req[2] = 1'b0;
    model_hang = 1'b0;
    repeat (3) @(negedge sys_clock);

    // Held request: 3 holds across its done while 1 waits -> 3, 1, 3
    model_result = 32'h0000_0077;
    model_busy_len = 10;
    push_exp(3, 32'h0000_0077, 1'b0);
    push_exp(1, 32'h0000_0077, 1'b0);
    push_exp(3, 32'h0000_0077, 1'b0);
    req[3] = 1'b1;
    repeat (2) @(negedge sys_clock);
    req[1] = 1'b1;
    wait_done(3, 200);
    wait_done(1, 200); req[1] = 1'b0;
    wait_done(3, 200); req[3] = 1'b0;
    repeat (3) @(negedge sys_clock);

    // Reset while in WAIT_DONE: no done, outputs cleared
    model_busy_len = 50;
    begin
      exp_ctrl_t c;
      c.idx = 2; c.data = dw[2];
      ctrl_q.push_back(c);
    end
    req[2] = 1'b1;
    wait_status(1'b1, 30);
    repeat (3) @(negedge sys_clock);
    reset = 1'b1;
    @(negedge sys_clock);
    check32("midrst_gnt", 32'(gnt), 32'h0);
    check32("midrst_done", 32'(done), 32'h0);
    check32("midrst_wr", 32'(m_wr_ctrl), 32'h0);
    check32("midrst_ctrl", m_ctrl_data, 32'h0);
    check32("midrst_rsp", rsp_status, 32'h0);
    reset = 1'b0;
    req[2] = 1'b0;
    wait_status(1'b0, 100);
    repeat (5) @(negedge sys_clock);

    // Fresh request after reset
    model_result = 32'h0000_0099;
    model_busy_len = 8;
    push_exp(1, 32'h0000_0099, 1'b0);
    req[1] = 1'b1;
    wait_done(1, 100); req[1] = 1'b0;
    repeat (5) @(negedge sys_clock);

    check32("ctrl_q_empty", 32'(ctrl_q.size()), 32'h0);
    check32("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and sequencer that shares one `I2C_master` between `N_REQ` requesters (sensor pollers, config loaders, firmware mailbox). It accepts 32-bit command words on a per-requester req/done handshake and picks one requester at a time. It drives the master's `ctrl_data`/`wr_ctrl` pair, tracks the master's busy flag to completion, and returns the captured master status to the winning requester. A timeout guards against a hung bus.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 65535: maximum `sys_clock` cycles from the `m_wr_ctrl` pulse to busy falling; 16-bit counter.
- `sys_clock`  in  1  system clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level.
- `req_data`  in  32*N_REQ  command word of requester i at bits [32i+31:32i]; format `{8'h00, slave_addr[7:0], reg_addr[7:0], data[7:0]}`.
- `gnt`  out  N_REQ  one-hot; high while requester i owns the master.
- `done`  out  N_REQ  one-cycle pulse to the owner at completion.
- `rsp_status`  out  32  captured completion status; valid in the `done` cycle and held until the next `done`.
- `m_ctrl_data`  out  32  to `I2C_master.ctrl_data`.
- `m_wr_ctrl`  out  1  to `I2C_master.wr_ctrl`; one-cycle start pulse.
- `m_status`  in  32  from `I2C_master.status`; bit 31 busy, bit 30 NACK, bits 7:0 read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND.
- **IDLE**
  - If any `req` is high, select the first requester at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - Latch its `req_data` into `m_ctrl_data` and set its `gnt` bit. Go to ISSUE.
- **ISSUE**
  - `m_wr_ctrl`=1 for exactly this cycle.
  - Clear the timeout counter. Go to WAIT_BUSY.
- **WAIT_BUSY**
  - Wait for `m_status[31]`=1, then go to WAIT_DONE.
  - The counter increments every cycle in this state.
- **WAIT_DONE**
  - Wait for `m_status[31]`=0.
  - On that cycle, capture `m_status` into `rsp_status` with bit 29 cleared. Go to RESPOND.
  - The counter keeps incrementing and is not cleared between WAIT_BUSY and WAIT_DONE.
- **Timeout**
  - Applies in WAIT_BUSY or WAIT_DONE when the counter reaches `TIMEOUT_CYCLES`.
  - `rsp_status` = `{2'b00, 1'b1, 29'h0}` (bit 29 marks timeout). Go to RESPOND.
- **RESPOND**
  - Pulse `done[owner]`. Set `rr_ptr` = owner+1 mod `N_REQ`.
  - Clear `gnt`. Go to IDLE.
- **Request rules**
  - `req[i]` must stay high and `req_data[i]` stable until `done[i]`.
  - Deasserting `req[i]` while granted has no effect; the transaction completes and `done` still pulses.
  - `req[i]` still high in the cycle after `done[i]` counts as a new request. It is arbitrated normally at lowest priority.
- `m_ctrl_data` holds the latched word from IDLE exit until the next grant. It is never changed while the master is busy.
- NACK (bit 30) is passed through unchanged and is not a timeout.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0.
  - `gnt`, `done`, `m_wr_ctrl`, `m_ctrl_data`, `rsp_status` all 0.
- Reset in any state aborts with no `done` pulse. The external master is not reset by this block.
- Latency, with `req` high in IDLE at cycle 0:
  - `gnt` and `m_ctrl_data` valid at cycle 1.
  - `m_wr_ctrl` high in cycle 2.
  - `done` 2 cycles after `m_status[31]` is first seen low in WAIT_DONE: capture edge, then RESPOND.
- Minimum gap between consecutive `m_wr_ctrl` pulses is set by master busy time plus 3 cycles.
- Simultaneous requests resolve on the round-robin pointer only; no fixed priority.

## Structure
- A shared package `i2c_pkg` holds:
  - status bit positions: `STAT_BUSY`=31, `STAT_NACK`=30, `STAT_TIMEOUT`=29;
  - the command-word field offsets;
  - the FSM state encoding.
- One sub-module, `rr_arbiter`: a combinational round-robin picker taking `req` vector and `rr_ptr`, producing a one-hot grant and grant index. It is reusable by other shared-bus blocks.

## Test plan
- **Single request.** Requester 0 sends `req_data`=32'h00665544 against the master model (busy 50 cycles) → `m_ctrl_data`=32'h00665544, one `m_wr_ctrl` pulse, `done[0]` once, `rsp_status[31:29]`=0.
- **Round-robin order.** `req[0]` and `req[2]` raised in the same cycle, `rr_ptr`=0 → 0 served, then 2. Re-raise both → 0 first again, because `rr_ptr`=3 wraps to 0. Exactly two `m_wr_ctrl` pulses per round.
- **Timeout.** `TIMEOUT_CYCLES`=100 and the model never raises busy → `done` 100 cycles after the `m_wr_ctrl` cycle (±1), `rsp_status`=32'h2000_0000.
- **NACK passthrough.** Model returns status 32'h4000_00A5 with busy low → `rsp_status`=32'h4000_00A5, no timeout bit.
- **Reset mid-transaction.** `reset` pulsed in WAIT_DONE → next cycle all outputs 0, no `done` pulse. A fresh `req[1]` is granted normally afterwards.
- **Held request.** Requester 3 keeps `req` high across its `done` while `req[1]` is pending → requester 1 granted before requester 3's second transaction.
